// File: rtl/instr_fetch_queue.sv
// Show-ahead prefetch FIFO of {instruction, PC} between Fetch and Decode.
// The head entry drives the Decode outputs; an empty queue presents a NOP bubble.
module instr_fetch_queue #(
    parameter  int WIDTH  = 32,
    parameter  int DEPTH  = 4,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              push_valid_i,
    output logic              push_ready_o,
    input  logic [WIDTH-1:0]  push_instr_i,
    input  logic [WIDTH-1:0]  push_pc_i,
    input  logic              pop_ready_i,
    output logic              pop_valid_o,
    output logic [WIDTH-1:0]  InstrD,
    output logic [WIDTH-1:0]  PCD,
    output logic [WIDTH-1:0]  PCplus4D,
    output logic [ADDR_W:0]   count_o
);

    localparam logic [WIDTH-1:0]  NOP_INSTR = WIDTH'(32'h0000_0013);
    localparam logic [ADDR_W:0]   FULL_CNT  = (ADDR_W+1)'(DEPTH);

    logic [2*WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0]  rd_ptr;
    logic [ADDR_W:0]    count_r;
    logic               push_fire;
    logic               pop_fire;
    logic [2*WIDTH-1:0] head;

    // Handshake: a transfer happens on a clock edge where valid and ready are
    // both high. Ready/valid here come from registered count only, so neither
    // depends combinationally on the other side's request.
    assign push_ready_o = (count_r != FULL_CNT);
    assign pop_valid_o  = (count_r != '0);
    assign push_fire    = push_valid_i & push_ready_o;
    assign pop_fire     = pop_valid_o & pop_ready_i;
    assign count_o      = count_r;

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_r <= '0;
        end else begin
            if (push_fire) wr_ptr <= wr_ptr + 1'b1;
            if (pop_fire)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_fire, pop_fire})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage is not reset; stale contents are masked by the empty decode below.
    always_ff @(posedge clk) begin
        if (!rst && !flush_i && push_fire)
            mem[wr_ptr] <= {push_instr_i, push_pc_i};
    end

    always_comb begin
        head     = mem[rd_ptr];
        InstrD   = NOP_INSTR;
        PCD      = '0;
        PCplus4D = '0;
        if (pop_valid_o) begin
            InstrD   = head[2*WIDTH-1:WIDTH];
            PCD      = head[WIDTH-1:0];
            PCplus4D = head[WIDTH-1:0] + WIDTH'(4);
        end
    end

endmodule
